// File: rtl/stp_loader.sv
`default_nettype none
// ============================================================================
//  Module      : stp_loader
//  Description : Set-polynomial engine. Validates a slot/degree request,
//                copies N+1 coefficients from the data RAM into the slot's
//                region of the S coefficient RAM, records the degree and
//                reports a result/status word pair on completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module stp_loader #(
    parameter int WORD_SIZE   = 16,
    parameter int BUFFER_SIZE = 1024,
    parameter int NUM_SLOTS   = 8,
    parameter int MAX_DEG     = 10,
    parameter int A_W         = 3,
    parameter int N_W         = 5,
    localparam int ADDR_W     = $clog2(BUFFER_SIZE),
    localparam int S_ADDR_W   = $clog2(NUM_SLOTS * (MAX_DEG + 1))
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [A_W-1:0]       A,
    input  logic [N_W-1:0]       N,
    input  logic [ADDR_W-1:0]    rd_ptr_in,
    input  logic [ADDR_W:0]      data_count,
    input  logic [WORD_SIZE-1:0] rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 en_rd_data,
    output logic [ADDR_W-1:0]    rd_addr_data,
    output logic                 en_wr_S,
    output logic [S_ADDR_W-1:0]  wr_addr_S,
    output logic [WORD_SIZE-1:0] wr_data_S,
    output logic                 en_wr_N,
    output logic [A_W-1:0]       wr_addr_N,
    output logic [N_W-1:0]       wr_data_N,
    output logic [ADDR_W-1:0]    rd_ptr_out,
    output logic [31:0]          result,
    output logic [31:0]          status
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CHECK = 3'd1;
    localparam logic [2:0] c_LOAD  = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    // Words reserved per slot in the S RAM
    localparam logic [S_ADDR_W-1:0] c_SLOT_WORDS = S_ADDR_W'(MAX_DEG + 1);

    // Status codes
    localparam logic [1:0] c_ST_OK       = 2'd0;
    localparam logic [1:0] c_ST_NO_DATA  = 2'd1;
    localparam logic [1:0] c_ST_BAD_DEG  = 2'd2;
    localparam logic [1:0] c_ST_BAD_SLOT = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]           state_q, state_d;
    logic [A_W-1:0]       a_q;
    logic [N_W-1:0]       n_q;
    logic [ADDR_W-1:0]    ptr_q;
    logic [ADDR_W:0]      cnt_q;
    logic [S_ADDR_W-1:0]  base_q;
    logic [N_W-1:0]       k_q;
    logic                 en_wr_s_q;
    logic [S_ADDR_W-1:0]  wr_addr_s_q;
    logic [ADDR_W-1:0]    rd_ptr_q;
    logic [31:0]          result_q;
    logic [31:0]          status_q;

    // Combinational helpers
    logic [1:0]           w_err;
    logic [S_ADDR_W-1:0]  w_base;
    logic                 w_load;

    assign w_load = (state_q == c_LOAD);
    assign w_base = S_ADDR_W'(a_q) * c_SLOT_WORDS;

    // Request validation, checked in priority order slot > degree > data
    always_comb begin
        w_err = c_ST_OK;
        if (32'(a_q) >= NUM_SLOTS) begin
            w_err = c_ST_BAD_SLOT;
        end else if (32'(n_q) > MAX_DEG) begin
            w_err = c_ST_BAD_DEG;
        end else if (32'(cnt_q) < (32'(n_q) + 32'd1)) begin
            w_err = c_ST_NO_DATA;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start only has an effect while idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d = c_CHECK;
                end
            end
            c_CHECK: begin
                if (w_err != c_ST_OK) begin
                    state_d = c_DONE;
                end else begin
                    state_d = c_LOAD;
                end
            end
            c_LOAD: begin
                if (k_q == n_q) begin
                    state_d = c_DRAIN;
                end
            end
            c_DRAIN: begin
                state_d = c_DONE;
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // FSM outputs: read port, degree-table write and handshake flags
    always_comb begin
        busy         = (state_q != c_IDLE);
        done         = (state_q == c_DONE);
        en_rd_data   = w_load;
        rd_addr_data = '0;
        en_wr_N      = 1'b0;
        wr_addr_N    = '0;
        wr_data_N    = '0;
        if (w_load) begin
            rd_addr_data = ptr_q + ADDR_W'(k_q);
            if (k_q == '0) begin
                en_wr_N   = 1'b1;
                wr_addr_N = a_q;
                wr_data_N = n_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Request latch, load counter and completion words
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            n_q      <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            k_q      <= '0;
            rd_ptr_q <= '0;
            result_q <= '0;
            status_q <= 32'hFFFF_FFFF;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        n_q   <= N;
                        ptr_q <= rd_ptr_in;
                        cnt_q <= data_count;
                    end
                end
                c_CHECK: begin
                    k_q    <= '0;
                    base_q <= w_base;
                    if (w_err != c_ST_OK) begin
                        result_q <= '0;
                        status_q <= 32'(w_err);
                    end
                end
                c_LOAD: begin
                    k_q <= k_q + N_W'(1);
                end
                c_DRAIN: begin
                    result_q <= 32'(n_q) + 32'd1;
                    status_q <= 32'(c_ST_OK);
                    rd_ptr_q <= ptr_q + ADDR_W'(n_q) + ADDR_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // S write pipeline: trails each read by one cycle to meet RAM latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_wr_s_q   <= 1'b0;
            wr_addr_s_q <= '0;
        end else begin
            en_wr_s_q   <= w_load;
            wr_addr_s_q <= w_load ? (base_q + S_ADDR_W'(k_q)) : '0;
        end
    end

    assign en_wr_S    = en_wr_s_q;
    assign wr_addr_S  = wr_addr_s_q;
    assign wr_data_S  = en_wr_s_q ? rd_data : '0;
    assign rd_ptr_out = rd_ptr_q;
    assign result     = result_q;
    assign status     = status_q;

endmodule
`default_nettype wire
